// File: rtl/ucsbece154b_branch_resolve_pkg.sv
// Shared opcodes, resolve-FSM states and helpers for the branch-resolve slice.
// RISC-V control-flow opcodes as seen in the E stage.
package ucsbece154b_branch_resolve_pkg;

  localparam logic [6:0] instr_branch_op = 7'b1100011;
  localparam logic [6:0] instr_jal_op    = 7'b1101111;
  localparam logic [6:0] instr_jalr_op   = 7'b1100111;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } resolve_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ucsbece154b_pred_pipe_reg.sv
// One pipeline stage of fetch-time prediction metadata.
// Flush wins over stall; a flushed stage holds a bubble with cleared payload.
module ucsbece154b_pred_pipe_reg #(
  parameter int W = 39
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         flush,
  input  logic         valid_d,
  input  logic [W-1:0] d,
  output logic         valid_q,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q <= 1'b0;
      q       <= '0;
    end else if (!stall) begin
      valid_q <= valid_d;
      q       <= d;
    end
  end

endmodule

// File: rtl/ucsbece154b_branch_resolve.sv
// Execute-stage branch resolution: compares carried predictions with real outcomes
// and drives predictor updates, misprediction redirect and statistics counters.
//
// state   | meaning
// RUN     | normal resolution of control flow in E
// RECOVER | one cycle after a mispredict; E is the squashed slot, no updates
module ucsbece154b_branch_resolve
  import ucsbece154b_branch_resolve_pkg::*;
#(
  parameter int NUM_BTB_ENTRIES = 32,
  parameter int NUM_GHR_BITS    = 5,
  localparam int BI             = $clog2(NUM_BTB_ENTRIES)
) (
  input  logic                    clk,
  input  logic                    reset_i,
  input  logic                    StallF_i,
  input  logic                    StallD_i,
  input  logic                    FlushD_i,
  input  logic                    FlushE_i,
  input  logic                    BranchTakenF_i,
  input  logic [31:0]             BTBtargetF_i,
  input  logic                    BTBhitF_i,
  input  logic [NUM_GHR_BITS-1:0] PHTreadaddressF_i,
  input  logic [6:0]              opE_i,
  input  logic [31:0]             PCE_i,
  input  logic [31:0]             PCTargetE_i,
  input  logic                    CondTakenE_i,
  output logic                    PHTwe_o,
  output logic                    PHTincrement_o,
  output logic [NUM_GHR_BITS-1:0] PHTwriteaddress_o,
  output logic                    BTB_we_o,
  output logic [BI-1:0]           BTBwriteaddress_o,
  output logic [31:0]             BTBwritedata_o,
  output logic                    GHRreset_o,
  output logic                    MispredictE_o,
  output logic [31:0]             PCRedirectE_o,
  output logic [31:0]             BranchCount_o,
  output logic [31:0]             MispredictCount_o
);

  localparam int W = 1 + 32 + 1 + NUM_GHR_BITS;

  logic                    valid_d, valid_e;
  logic [W-1:0]            meta_f, meta_d, meta_e;
  logic                    pred_taken_e, btb_hit_e;
  logic [31:0]             pred_target_e;
  logic [NUM_GHR_BITS-1:0] pht_addr_e;
  resolve_state_t          state;
  logic                    is_b, is_j, cf, actual, tgt_diff, mispredict;
  logic                    unused_stall_f;

  // The fetch-side hold is applied by the PC register; D's enable is StallD.
  assign unused_stall_f = StallF_i;

  assign meta_f = {BranchTakenF_i, BTBtargetF_i, BTBhitF_i, PHTreadaddressF_i};

  ucsbece154b_pred_pipe_reg #(.W(W)) u_pipe_d (
    .clk     (clk),
    .reset   (reset_i),
    .stall   (StallD_i),
    .flush   (FlushD_i),
    .valid_d (1'b1),
    .d       (meta_f),
    .valid_q (valid_d),
    .q       (meta_d)
  );

  ucsbece154b_pred_pipe_reg #(.W(W)) u_pipe_e (
    .clk     (clk),
    .reset   (reset_i),
    .stall   (1'b0),
    .flush   (FlushE_i),
    .valid_d (valid_d),
    .d       (meta_d),
    .valid_q (valid_e),
    .q       (meta_e)
  );

  assign {pred_taken_e, pred_target_e, btb_hit_e, pht_addr_e} = meta_e;

  // Reset gates cf so a stale E slot cannot update the predictor in the reset cycle.
  assign is_b       = (opE_i == instr_branch_op);
  assign is_j       = (opE_i == instr_jal_op) || (opE_i == instr_jalr_op);
  assign cf         = valid_e && (state == RUN) && (is_b || is_j) && !reset_i;
  assign actual     = is_j || (is_b && CondTakenE_i);
  assign tgt_diff   = (pred_target_e != PCTargetE_i);
  assign mispredict = cf && ((actual != pred_taken_e) || (actual && tgt_diff));

  assign MispredictE_o     = mispredict;
  assign GHRreset_o        = mispredict;
  assign PCRedirectE_o     = !cf ? 32'd0 : (actual ? PCTargetE_i : PCE_i + 32'd4);
  assign PHTwe_o           = cf && is_b;
  assign PHTincrement_o    = CondTakenE_i;
  assign PHTwriteaddress_o = pht_addr_e;
  assign BTB_we_o          = cf && actual && (!btb_hit_e || tgt_diff);
  assign BTBwriteaddress_o = PCE_i[BI+1:2];
  assign BTBwritedata_o    = PCTargetE_i;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state             <= RUN;
      BranchCount_o     <= 32'd0;
      MispredictCount_o <= 32'd0;
    end else begin
      case (state)
        RUN:     if (mispredict) state <= RECOVER;
        RECOVER: state <= RUN;
        default: state <= RUN;
      endcase
      if (cf)         BranchCount_o     <= sat_inc(BranchCount_o);
      if (mispredict) MispredictCount_o <= sat_inc(MispredictCount_o);
    end
  end

endmodule

// File: tb/tb_ucsbece154b_branch_resolve.sv
// Directed self-checking bench for ucsbece154b_branch_resolve with an expected-result
// queue and a small reference model of the E-stage resolution.
module tb_ucsbece154b_branch_resolve;

  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ALU  = 7'b0110011;

  logic        clk = 1'b0;
  logic        reset_i, stall_f, stall_d, flush_d, flush_e;
  logic        taken_f, hit_f, cond_e;
  logic [31:0] target_f, pc_e, tgt_e;
  logic [4:0]  pht_f;
  logic [6:0]  op_e;
  logic        pht_we, pht_inc, btb_we, ghr_reset, mispredict;
  logic [4:0]  pht_waddr, btb_waddr;
  logic [31:0] btb_wdata, redirect, branch_count, mispredict_count;

  typedef struct {
    logic        mis;
    logic [31:0] redir;
    logic        phtwe;
    logic        inc;
    logic [4:0]  phta;
    logic        btbwe;
    logic [4:0]  btba;
    logic [31:0] btbd;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail = 0;
  logic        m_recover = 1'b0;
  logic        m_pend_cf = 1'b0;
  logic        m_pend_mis = 1'b0;
  logic [31:0] m_bcnt = 32'd0;
  logic [31:0] m_mcnt = 32'd0;

  always #5 clk = ~clk;

  ucsbece154b_branch_resolve dut (
    .clk               (clk),
    .reset_i           (reset_i),
    .StallF_i          (stall_f),
    .StallD_i          (stall_d),
    .FlushD_i          (flush_d),
    .FlushE_i          (flush_e),
    .BranchTakenF_i    (taken_f),
    .BTBtargetF_i      (target_f),
    .BTBhitF_i         (hit_f),
    .PHTreadaddressF_i (pht_f),
    .opE_i             (op_e),
    .PCE_i             (pc_e),
    .PCTargetE_i       (tgt_e),
    .CondTakenE_i      (cond_e),
    .PHTwe_o           (pht_we),
    .PHTincrement_o    (pht_inc),
    .PHTwriteaddress_o (pht_waddr),
    .BTB_we_o          (btb_we),
    .BTBwriteaddress_o (btb_waddr),
    .BTBwritedata_o    (btb_wdata),
    .GHRreset_o        (ghr_reset),
    .MispredictE_o     (mispredict),
    .PCRedirectE_o     (redirect),
    .BranchCount_o     (branch_count),
    .MispredictCount_o (mispredict_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and retire the model's pending state/counter effects.
  task automatic tick();
    @(posedge clk);
    if (reset_i) begin
      m_recover = 1'b0;
      m_bcnt    = 32'd0;
      m_mcnt    = 32'd0;
    end else begin
      m_recover = m_pend_mis;
      if (m_pend_cf && m_bcnt != 32'hFFFF_FFFF) m_bcnt++;
      if (m_pend_mis && m_mcnt != 32'hFFFF_FFFF) m_mcnt++;
    end
    m_pend_cf  = 1'b0;
    m_pend_mis = 1'b0;
    @(negedge clk);
  endtask

  task automatic drive_f(input logic t, input logic [31:0] tg, input logic h, input logic [4:0] pa);
    taken_f = t; target_f = tg; hit_f = h; pht_f = pa;
  endtask

  // Drive the E-stage instruction whose metadata (vld/pt/ptg/ph/pa) the bench knows
  // is sitting in E, queue the expectation, then compare.
  task automatic exec(input string tag, input logic vld, input logic pt, input logic [31:0] ptg,
                      input logic ph, input logic [4:0] pa, input logic [6:0] op,
                      input logic [31:0] pc, input logic [31:0] tg, input logic cond);
    exp_t e, got;
    logic is_j, is_b, cf, act;
    op_e = op; pc_e = pc; tgt_e = tg; cond_e = cond;
    is_b = (op == OP_BR);
    is_j = (op == OP_JAL) || (op == OP_JALR);
    cf   = vld && !m_recover && !reset_i && (is_b || is_j);
    act  = is_j || (is_b && cond);
    e.mis   = cf && ((act && (!pt || ptg != tg)) || (!act && pt));
    e.redir = !cf ? 32'd0 : (act ? tg : pc + 32'd4);
    e.phtwe = cf && is_b;
    e.inc   = cond;
    e.phta  = pa;
    e.btbwe = cf && act && (!ph || ptg != tg);
    e.btba  = pc[6:2];
    e.btbd  = tg;
    sb.push_back(e);
    m_pend_cf  = cf;
    m_pend_mis = e.mis;
    #1;
    got = sb.pop_front();
    chk({tag, ".mispredict"}, {31'd0, mispredict}, {31'd0, got.mis});
    chk({tag, ".ghr_reset"},  {31'd0, ghr_reset},  {31'd0, got.mis});
    chk({tag, ".redirect"},   redirect,            got.redir);
    chk({tag, ".pht_we"},     {31'd0, pht_we},     {31'd0, got.phtwe});
    chk({tag, ".pht_inc"},    {31'd0, pht_inc},    {31'd0, got.inc});
    chk({tag, ".pht_addr"},   {27'd0, pht_waddr},  {27'd0, got.phta});
    chk({tag, ".btb_we"},     {31'd0, btb_we},     {31'd0, got.btbwe});
    chk({tag, ".btb_addr"},   {27'd0, btb_waddr},  {27'd0, got.btba});
    chk({tag, ".btb_data"},   btb_wdata,           got.btbd);
    chk({tag, ".branch_cnt"}, branch_count,        m_bcnt);
    chk({tag, ".mis_cnt"},    mispredict_count,    m_mcnt);
  endtask

  // Fetch one prediction, let it reach E, then resolve it.
  task automatic run_cf(input string tag, input logic pt, input logic [31:0] ptg, input logic ph,
                        input logic [4:0] pa, input logic [6:0] op, input logic [31:0] pc,
                        input logic [31:0] tg, input logic cond);
    drive_f(pt, ptg, ph, pa);
    tick();
    drive_f(1'b0, 32'd0, 1'b0, 5'd0);
    tick();
    exec(tag, 1'b1, pt, ptg, ph, pa, op, pc, tg, cond);
    tick();
    op_e = OP_ALU; cond_e = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0; flush_e = 1'b0;
    drive_f(1'b0, 32'd0, 1'b0, 5'd0);
    op_e = OP_ALU; pc_e = 32'd0; tgt_e = 32'd0; cond_e = 1'b0;
    @(negedge clk);
    tick();
    exec("reset", 1'b0, 1'b0, 32'd0, 1'b0, 5'd0, OP_BR, 32'd0, 32'd0, 1'b0);
    tick();
    reset_i = 1'b0;
    op_e = OP_ALU;
    tick();

    run_cf("beq_nt_taken", 1'b0, 32'd0,     1'b0, 5'd5,  OP_BR,   32'h40, 32'h80,  1'b1);
    run_cf("beq_t_nt",     1'b1, 32'h80,    1'b1, 5'd6,  OP_BR,   32'h40, 32'h80,  1'b0);
    run_cf("jal_hit",      1'b1, 32'h200,   1'b1, 5'd7,  OP_JAL,  32'h50, 32'h200, 1'b0);
    run_cf("jalr_badtgt",  1'b1, 32'h100,   1'b1, 5'd8,  OP_JALR, 32'h60, 32'h200, 1'b0);
    run_cf("beq_nt_ok",    1'b0, 32'd0,     1'b0, 5'd9,  OP_BR,   32'h7C, 32'h10,  1'b0);
    run_cf("beq_pc_wrap",  1'b1, 32'h1000,  1'b1, 5'd31, OP_BR,   32'hFFFF_FFFC, 32'h1000, 1'b0);
    run_cf("jal_miss",     1'b1, 32'h300,   1'b0, 5'd1,  OP_JAL,  32'h84, 32'h300, 1'b0);
    run_cf("alu_ignored",  1'b1, 32'h44,    1'b1, 5'd2,  OP_ALU,  32'h88, 32'h44,  1'b1);

    // StallD holds metadata in D for 3 cycles; E keeps receiving the same entry.
    drive_f(1'b1, 32'h340, 1'b1, 5'd12);
    tick();
    stall_d = 1'b1;
    drive_f(1'b0, 32'h999, 1'b0, 5'd3);
    tick(); tick(); tick();
    stall_d = 1'b0;
    exec("stall_held", 1'b1, 1'b1, 32'h340, 1'b1, 5'd12, OP_JAL, 32'h90, 32'h340, 1'b0);
    tick();
    op_e = OP_ALU; flush_e = 1'b1;
    tick();
    flush_e = 1'b0;
    exec("flush_bubble", 1'b0, 1'b0, 32'd0, 1'b0, 5'd0, OP_BR, 32'h94, 32'h20, 1'b1);
    tick();
    op_e = OP_ALU; cond_e = 1'b0;
    drive_f(1'b0, 32'd0, 1'b0, 5'd0);
    tick(); tick();

    // Back-to-back: mispredict, then the following branch lands in the RECOVER slot.
    drive_f(1'b0, 32'd0, 1'b0, 5'd3);
    tick();
    drive_f(1'b0, 32'd0, 1'b0, 5'd4);
    tick();
    drive_f(1'b0, 32'd0, 1'b0, 5'd0);
    exec("b2b_first",  1'b1, 1'b0, 32'd0, 1'b0, 5'd3, OP_BR, 32'h40, 32'h80, 1'b1);
    tick();
    exec("b2b_second", 1'b1, 1'b0, 32'd0, 1'b0, 5'd4, OP_BR, 32'h80, 32'hC0, 1'b1);
    tick();
    op_e = OP_ALU; cond_e = 1'b0;
    tick();

    // Reset asserted while in RECOVER.
    drive_f(1'b0, 32'd0, 1'b0, 5'd10);
    tick();
    drive_f(1'b0, 32'd0, 1'b0, 5'd0);
    tick();
    exec("pre_rst_mis", 1'b1, 1'b0, 32'd0, 1'b0, 5'd10, OP_BR, 32'h40, 32'h80, 1'b1);
    tick();
    reset_i = 1'b1;
    exec("rst_in_recover", 1'b1, 1'b0, 32'd0, 1'b0, 5'd0, OP_BR, 32'h40, 32'h80, 1'b0);
    tick();
    reset_i = 1'b0;
    op_e = OP_ALU;
    chk("post_rst.branch_cnt", branch_count, 32'd0);
    chk("post_rst.mis_cnt", mispredict_count, 32'd0);
    tick();
    run_cf("after_reset_run", 1'b0, 32'd0, 1'b0, 5'd11, OP_BR, 32'h40, 32'h80, 1'b1);

    chk("final.branch_cnt", branch_count, m_bcnt);
    chk("final.mis_cnt", mispredict_count, m_mcnt);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
